// File: rtl/median_window_sequencer.sv
// Raster-order 3x3 window sequencer feeding a median datapath and a byte stream.
// Define BORDER_REPLICATE_EN to filter border pixels with edge-replicated windows.
module median_window_sequencer #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int ADDR_W  = 12,
  parameter int MED_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [71:0]       win_flat,
  output logic              win_valid,
  input  logic [7:0]        med_val,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int XW = $clog2(IMG_W + 2);
  localparam int YW = $clog2(IMG_H + 2);
  localparam int CW = $clog2(MED_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MED,
    S_SEND,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [3:0]      r_k;
  logic [CW-1:0]   r_cnt;
  logic [71:0]     r_win;
  logic [7:0]      r_tx;

  logic            w_last_x;
  logic            w_last_y;
  logic            w_border;
  logic [1:0]      w_dy;
  logic [1:0]      w_dx;
  logic [XW-1:0]   w_xr;
  logic [YW-1:0]   w_yr;
  logic [XW-1:0]   w_col;
  logic [YW-1:0]   w_row;
  logic            w_rd_en;
  logic            w_fetch_done;
  logic            w_med_ready;

  assign w_last_x    = (r_x == XW'(IMG_W - 1));
  assign w_last_y    = (r_y == YW'(IMG_H - 1));
  assign w_med_ready = (r_cnt == CW'(MED_LAT));

`ifdef BORDER_REPLICATE_EN
  assign w_border = 1'b0;
`else
  assign w_border = (r_x == '0) || w_last_x || (r_y == '0) || w_last_y;
`endif

  // Border pixels in skip mode read only the centre, i.e. offset (1,1).
  always_comb begin
    w_dy = 2'd1;
    w_dx = 2'd1;
    if (!w_border) begin
      case (r_k)
        4'd0:    begin w_dy = 2'd0; w_dx = 2'd0; end
        4'd1:    begin w_dy = 2'd0; w_dx = 2'd1; end
        4'd2:    begin w_dy = 2'd0; w_dx = 2'd2; end
        4'd3:    begin w_dy = 2'd1; w_dx = 2'd0; end
        4'd4:    begin w_dy = 2'd1; w_dx = 2'd1; end
        4'd5:    begin w_dy = 2'd1; w_dx = 2'd2; end
        4'd6:    begin w_dy = 2'd2; w_dx = 2'd0; end
        4'd7:    begin w_dy = 2'd2; w_dx = 2'd1; end
        4'd8:    begin w_dy = 2'd2; w_dx = 2'd2; end
        default: begin w_dy = 2'd1; w_dx = 2'd1; end
      endcase
    end
  end

  // Coordinates are biased by +1 so the -1 neighbour never underflows; clamp then unbias.
  always_comb begin
    w_xr = r_x + XW'(w_dx);
    w_yr = r_y + YW'(w_dy);
    if (w_xr == '0)
      w_col = '0;
    else if (w_xr > XW'(IMG_W))
      w_col = XW'(IMG_W - 1);
    else
      w_col = w_xr - 1'b1;
    if (w_yr == '0)
      w_row = '0;
    else if (w_yr > YW'(IMG_H))
      w_row = YW'(IMG_H - 1);
    else
      w_row = w_yr - 1'b1;
  end

  assign w_rd_en      = (r_state == S_FETCH) && (w_border ? (r_k == 4'd0) : (r_k < 4'd9));
  assign w_fetch_done = w_border ? (r_k == 4'd1) : (r_k == 4'd9);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_FETCH;
      S_FETCH:    if (w_fetch_done) w_next = w_border ? S_SEND : S_WAIT_MED;
      S_WAIT_MED: if (w_med_ready) w_next = S_SEND;
      S_SEND:     if (tx_ready) w_next = S_ADVANCE;
      S_ADVANCE:  w_next = (w_last_x && w_last_y) ? S_DONE : S_FETCH;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_win   <= '0;
      r_tx    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x <= '0;
            r_y <= '0;
            r_k <= '0;
          end
        end
        S_FETCH: begin
          r_k <= r_k + 1'b1;
          if (w_border) begin
            if (r_k == 4'd1) r_tx <= mem_rd_data;
          end else begin
            for (int unsigned i = 0; i < 9; i++) begin
              if (r_k == 4'(i + 1)) r_win[8*i +: 8] <= mem_rd_data;
            end
          end
          if (w_fetch_done) r_cnt <= '0;
        end
        S_WAIT_MED: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_med_ready) r_tx <= med_val;
        end
        S_ADVANCE: begin
          r_k <= '0;
          if (w_last_x) begin
            r_x <= '0;
            r_y <= w_last_y ? '0 : r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        S_DONE: begin
          r_x <= '0;
          r_y <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign mem_rd_en = w_rd_en;
  assign mem_addr  = w_rd_en ? (ADDR_W'(w_row) * ADDR_W'(IMG_W) + ADDR_W'(w_col)) : '0;
  assign win_flat  = r_win;
  assign win_valid = (r_state == S_WAIT_MED) && (r_cnt == '0);
  assign tx_data   = r_tx;
  assign tx_valid  = (r_state == S_SEND);

endmodule

// File: tb/tb_median_window_sequencer.sv
// Randomized self-checking bench for median_window_sequencer on a 4x4 frame.
// Honours BORDER_REPLICATE_EN the same way the design does.
module tb_median_window_sequencer;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 8;
  localparam int ML   = 2;
  localparam int NPIX = W * H;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic [71:0]   win_flat;
  logic          win_valid;
  logic [7:0]    med_val;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [95:0]   outs;

  logic [7:0] mem [NPIX];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  got_cnt = 0;
  int  done_cnt = 0;
  int  addr_bad = 0;
  int  rd_tx_bad = 0;
  int  cyc = 0;
  int  rd_start = 0;
  int  win_cyc = 0;
  int  rdy_mode = 0;
  bit  ident = 0;
  bit  stalled = 0;
  bit  pend_win = 0;
  bit  prev_rd = 0;
  bit  prev_tx = 0;
  bit  prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic [7:0] med_hold;
  int  med_cnt;

  median_window_sequencer #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW),
    .MED_LAT(ML)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .win_flat   (win_flat),
    .win_valid  (win_valid),
    .med_val    (med_val),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  assign outs = {3'b000, busy, done, mem_rd_en, mem_addr, win_flat, win_valid, tx_data, tx_valid};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pure coordinate arithmetic over the memory image.
  function automatic bit is_filt(input int p);
`ifdef BORDER_REPLICATE_EN
    return 1'b1;
`else
    int x = p % W;
    int y = p / W;
    return !(x == 0 || x == W - 1 || y == 0 || y == H - 1);
`endif
  endfunction

  function automatic logic [71:0] exp_win(input int p);
    logic [71:0] w = '0;
    for (int k = 0; k < 9; k++) begin
      int yy = p / W + k / 3 - 1;
      int xx = p % W + k % 3 - 1;
      if (yy < 0) yy = 0;
      if (yy > H - 1) yy = H - 1;
      if (xx < 0) xx = 0;
      if (xx > W - 1) xx = W - 1;
      w[8*k +: 8] = mem[yy * W + xx];
    end
    return w;
  endfunction

  function automatic logic [7:0] median9(input logic [71:0] w);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = w[8*i +: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  function automatic logic [7:0] exp_byte(input int p);
    return is_filt(p) ? median9(exp_win(p)) : mem[p];
  endfunction

  // Frame buffer with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr[3:0]];
  end

  // Median datapath: result valid exactly ML cycles after win_valid, garbage otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      med_cnt  <= 0;
      med_hold <= '0;
    end else if (win_valid) begin
      med_hold <= median9(win_flat);
      med_cnt  <= 1;
    end else if (med_cnt != 0 && med_cnt < 8) begin
      med_cnt <= med_cnt + 1;
    end
  end
  assign med_val = (med_cnt == ML) ? med_hold : ~med_hold;

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 2) stalled = 1'b0;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stalled && tx_valid && got_cnt == 6) begin
            tx_ready = 1'b0;
            stalled  = 1'b1;
            repeat (50) @(posedge clk);
            #1 tx_ready = 1'b1;
          end else begin
            tx_ready = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
      prev_tx    = 1'b0;
      pend_win   = 1'b0;
    end else begin
      if (start && !busy) begin
        got_cnt = 0; done_cnt = 0; addr_bad = 0; rd_tx_bad = 0;
      end
      if (mem_rd_en && !prev_rd) rd_start = cyc;
      if (mem_rd_en && mem_addr >= AW'(NPIX)) addr_bad++;
      if (mem_rd_en && tx_valid) rd_tx_bad++;
      if (prev_stall) chk("tx_hold", 96'({tx_valid, tx_data}), 96'({1'b1, prev_data}));
      if (win_valid) begin
        chk("win_filtered", 96'(is_filt(got_cnt)), 96'(1));
        chk("win_flat", 96'(win_flat), 96'(exp_win(got_cnt)));
        chk("win_latency", 96'(cyc - rd_start), 96'(10));
`ifdef BORDER_REPLICATE_EN
        if (ident && got_cnt == 0) chk("win_0_0", 96'(win_flat), 96'(72'h05_04_04_01_00_00_01_00_00));
`else
        if (ident && got_cnt == 5) chk("win_1_1", 96'(win_flat), 96'(72'h0a_09_08_06_05_04_02_01_00));
`endif
        pend_win = 1'b1;
        win_cyc  = cyc;
      end
      if (tx_valid && !prev_tx) begin
        if (pend_win) chk("med_latency", 96'(cyc - win_cyc), 96'(ML + 1));
        else          chk("border_latency", 96'(cyc - rd_start), 96'(2));
        pend_win = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (got_cnt < NPIX) chk("tx_byte", 96'(tx_data), 96'(exp_byte(got_cnt)));
        else                chk("extra_byte", 96'(got_cnt), 96'(NPIX - 1));
        got_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 96'(busy), 96'(0));
        chk("bytes_at_done", 96'(got_cnt), 96'(NPIX));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_rd    = mem_rd_en;
      prev_tx    = tx_valid;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_frame(input bit restart);
    int n;
    pulse_start();
    #1 chk("busy_after_start", 96'(busy), 96'(1));
    if (restart) begin
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("done_pulses", 96'(done_cnt), 96'(1));
    chk("frame_bytes", 96'(got_cnt), 96'(NPIX));
    chk("addr_range", 96'(addr_bad), 96'(0));
    chk("rd_during_tx", 96'(rd_tx_bad), 96'(0));
    chk("idle_after_frame", 96'({busy, tx_valid, mem_rd_en}), 96'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, '0);
    rst_n = 1'b1;

    ident = 1'b1; rdy_mode = 0; run_frame(1'b0); ident = 1'b0;
    rand_mem(); rdy_mode = 1; run_frame(1'b0);
    rand_mem(); rdy_mode = 2; run_frame(1'b0);
    rand_mem(); rdy_mode = 0; run_frame(1'b1);

    rand_mem(); rdy_mode = 1;
    pulse_start();
    n = 0;
    while (got_cnt < 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", outs, '0);
    chk("abort_bytes", 96'(got_cnt), 96'(5));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 96'(done_cnt), 96'(0));
    chk("abort_idle", 96'({busy, tx_valid, mem_rd_en}), 96'(0));
    run_frame(1'b0);

    for (int f = 0; f < 3; f++) begin
      rand_mem();
      rdy_mode = 1;
      run_frame(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
